midi_rx_ctrl: RTL and testbench

Receive-side controller for the MIDI input path. It sequences the 7-bit sample timer and serial shift datapath through start, data and stop bits at 31250 baud. It frames each byte and flags framing errors. It also assembles complete channel messages for downstream note logic, with optional running status. It sits between the raw `in` line of `receiver` and the synthesiser/display logic.

---
 rtl/midi_rx_ctrl.sv | 177 +++++++++++++++++
 tb/tb_midi_rx_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_rx_ctrl.sv
// MIDI 31250-baud receiver: byte framing plus channel-message assembly.
// Define MIDI_RX_RUNNING_STATUS_EN to keep running status across messages.
module midi_rx_ctrl #(
    parameter int CLKS_PER_BIT = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] msg_status,
    output logic [7:0] msg_d1,
    output logic [7:0] msg_d2,
    output logic       msg_valid
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          s1;
    logic          s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    sh;
    logic [2:0]    bidx;
    logic          brk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s  <= 1'b1;
        end else begin
            s1 <= in;
            s  <= s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= 8'h00;
            bidx       <= 3'd0;
            brk        <= 1'b0;
            data       <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    // a break must end before the next start is honoured
                    if (brk) begin
                        if (s) brk <= 1'b0;
                    end else if (!s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt  <= '0;
                        bidx <= 3'd0;
                        state <= s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        sh   <= {s, sh[7:1]};
                        bidx <= bidx + 3'd1;
                        if (bidx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (s) begin
                            data       <= sh;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    logic [7:0] rs;
    logic       rs_ok;
    logic       idx;
    logic [7:0] pd1;
    logic       one;
    logic       rs_keep;
    logic       is_rt;
    logic       is_sys;
    logic       is_ch;
    logic       is_dat;

`ifdef MIDI_RX_RUNNING_STATUS_EN
    assign rs_keep = 1'b1;
`else
    assign rs_keep = 1'b0;
`endif

    assign one    = (rs[7:5] == 3'b110);
    assign is_rt  = (data[7:3] == 5'b11111);
    assign is_sys = (data[7:3] == 5'b11110);
    assign is_ch  = data[7] && (data[7:4] != 4'hF);
    assign is_dat = !data[7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs         <= 8'h00;
            rs_ok      <= 1'b0;
            idx        <= 1'b0;
            pd1        <= 8'h00;
            msg_status <= 8'h00;
            msg_d1     <= 8'h00;
            msg_d2     <= 8'h00;
            msg_valid  <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            if (byte_valid) begin
                unique case (1'b1)
                    is_rt: begin
                        msg_valid  <= 1'b1;
                        msg_status <= data;
                        msg_d1     <= 8'h00;
                        msg_d2     <= 8'h00;
                    end
                    is_sys: rs_ok <= 1'b0;
                    is_ch: begin
                        rs    <= data;
                        rs_ok <= 1'b1;
                        idx   <= 1'b0;
                    end
                    is_dat: begin
                        if (rs_ok) begin
                            if (!idx && !one) begin
                                pd1 <= data;
                                idx <= 1'b1;
                            end else begin
                                msg_valid  <= 1'b1;
                                msg_status <= rs;
                                msg_d1     <= idx ? pd1 : data;
                                msg_d2     <= idx ? data : 8'h00;
                                idx        <= 1'b0;
                                rs_ok      <= rs_keep;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_rx_ctrl.sv
// Randomized bench for midi_rx_ctrl against a byte-level message model.
module tb_midi_rx_ctrl;
    localparam int CPB    = 128;
    localparam int BV_LAT = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       in;
    logic [7:0] data;
    logic       byte_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] msg_status;
    logic [7:0] msg_d1;
    logic [7:0] msg_d2;
    logic       msg_valid;

    midi_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .data      (data),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .msg_status(msg_status),
        .msg_d1    (msg_d1),
        .msg_d2    (msg_d2),
        .msg_valid (msg_valid)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_bv = 0, n_fe = 0, n_msg = 0;
    int e_bv = 0, e_fe = 0, e_msg = 0;
    ev_t q_bv[$];
    ev_t q_fe[$];
    ev_t q_msg[$];
    int mrs = -1;
    logic [7:0] mlast = 8'h00;
    logic [7:0] pend[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Byte-level reference: what MIDI says each received byte should do.
    function automatic void model_byte(input logic [7:0] b, input int t);
        ev_t e;
        int need;
        e.cyc = t; e.a = b; e.b = 8'h00; e.c = 8'h00;
        q_bv.push_back(e);
        e_bv++;
        mlast = b;
        if (b >= 8'hF8) begin
            e.cyc = t + 1;
            q_msg.push_back(e);
            e_msg++;
        end else if (b >= 8'hF0) begin
            mrs = -1;
            pend.delete();
        end else if (b >= 8'h80) begin
            mrs = int'(b);
            pend.delete();
        end else if (mrs >= 0) begin
            pend.push_back(b);
            need = (mrs >= 'hC0 && mrs <= 'hDF) ? 1 : 2;
            if (pend.size() == need) begin
                e.cyc = t + 1;
                e.a = 8'(mrs);
                e.b = pend[0];
                e.c = (need == 2) ? pend[1] : 8'h00;
                q_msg.push_back(e);
                e_msg++;
                pend.delete();
`ifndef MIDI_RX_RUNNING_STATUS_EN
                mrs = -1;
`endif
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit ok,
                             input int stop_len, input int gap);
        int tf;
        ev_t e;
        @(posedge clk);
        #1 in = 1'b0;
        tf = cyc;
        if (ok) begin
            model_byte(b, tf + BV_LAT);
        end else begin
            e.cyc = tf + BV_LAT; e.a = mlast; e.b = 8'h00; e.c = 8'h00;
            q_fe.push_back(e);
            e_fe++;
        end
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 in = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 in = ok;
        repeat (stop_len) @(posedge clk);
        #1 in = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic counts(input string tag);
        chk({tag, "_bv"}, n_bv, e_bv);
        chk({tag, "_fe"}, n_fe, e_fe);
        chk({tag, "_msg"}, n_msg, e_msg);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            if (byte_valid) begin
                n_bv++;
                if (q_bv.size() > 0) begin
                    e = q_bv.pop_front();
                    chk("bv_data", data, e.a);
                    chk("bv_cyc", cyc, e.cyc);
                end
            end
            if (frame_err) begin
                n_fe++;
                if (q_fe.size() > 0) begin
                    e = q_fe.pop_front();
                    chk("fe_data", data, e.a);
                    chk("fe_cyc", cyc, e.cyc);
                end
            end
            if (msg_valid) begin
                n_msg++;
                if (q_msg.size() > 0) begin
                    e = q_msg.pop_front();
                    chk("msg_st", msg_status, e.a);
                    chk("msg_d1", msg_d1, e.b);
                    chk("msg_d2", msg_d2, e.c);
                    chk("msg_cyc", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int nb;
        int r;
        logic [7:0] b;
        reset = 1'b0;
        in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bv", byte_valid, 1'b0);
        chk("rst_msg", {msg_status, msg_d1, msg_d2}, 24'h0);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        send_byte(8'h90, 1'b1, CPB, 4);
        send_byte(8'h3C, 1'b1, CPB, 4);
        send_byte(8'h64, 1'b1, CPB, 4);
        counts("note_on");

        send_byte(8'h3C, 1'b1, CPB, 2);
        send_byte(8'h00, 1'b1, CPB, 2);
        counts("running");

        nb = 0;
        @(posedge clk);
        #1 in = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 20) in = 1'b1;
            nb += int'(busy);
        end
        chk("glitch_busy", nb, 64);
        counts("glitch");

        send_byte(8'h55, 1'b0, CPB, 8);
        send_byte(8'h55, 1'b0, 600, 8);
        chk("fe_hold", data, 8'h00);
        counts("frame");

        send_byte(8'h90, 1'b1, CPB, 0);
        send_byte(8'hF8, 1'b1, CPB, 0);
        send_byte(8'h3C, 1'b1, CPB, 0);
        send_byte(8'h64, 1'b1, CPB, 3);
        counts("realtime");

        send_byte(8'h90, 1'b1, BV_LAT - 9 * CPB - 1, 0);
        send_byte(8'h3C, 1'b1, BV_LAT - 9 * CPB - 1, 0);
        send_byte(8'h64, 1'b1, CPB, 3);
        counts("b2b");

        @(posedge clk);
        #1 in = 1'b0;
        repeat (503) @(posedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_msg", {msg_status, msg_d1, msg_d2}, 24'h0);
        chk("mid_rst_pulse", {byte_valid, frame_err, msg_valid}, 3'b000);
        in = 1'b1;
        mrs = -1;
        pend.delete();
        mlast = 8'h00;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        send_byte(8'hC0, 1'b1, CPB, 2);
        send_byte(8'h05, 1'b1, CPB, 2);
        counts("post_rst");

        for (int k = 0; k < 25; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)       b = 8'($urandom_range(8'h00, 8'h7F));
            else if (r < 7)  b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r == 7) b = 8'($urandom_range(8'hC0, 8'hDF));
            else if (r == 8) b = 8'($urandom_range(8'hF8, 8'hFF));
            else             b = 8'($urandom_range(8'hF0, 8'hF7));
            send_byte(b, $urandom_range(0, 7) != 0, CPB,
                      int'($urandom_range(0, 12)));
        end
        repeat (20) @(posedge clk);
        counts("random");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
